// File: rtl/arb_pkg.sv
// Shared definitions for the eight-way round-robin arbiter:
// requester count, encoded index width, FSM state type and a one-hot helper.
package arb_pkg;

    localparam int NREQ = 8;
    localparam int ID_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Expand a 3-bit requester index into its one-hot grant vector.
    function automatic logic [NREQ-1:0] onehot8(input logic [ID_W-1:0] id);
        return {{(NREQ-1){1'b0}}, 1'b1} << id;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin winner picker: finds the first set request bit
// after the last-served index, wrapping modulo 8, so ptr itself is lowest.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] win_id,
    output logic            win_vld
);

    logic [ID_W-1:0]   start;
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [ID_W-1:0]   idx;

    // Scan starts one past the last-served index; 3-bit wrap makes ptr=7 start at 0.
    assign start = ptr + ID_W'(1);

    // Doubling req lets a plain part-select act as a rotate right by start.
    assign dbl = {req, req};
    assign rot = dbl[start +: NREQ];

    // Priority-encode the lowest set bit of the rotated request vector.
    always_comb begin
        idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                idx = ID_W'(i);
            end
        end
    end

    assign win_vld = |req;
    assign win_id  = idx + start;

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with bounded grant hold and active-low enable.
// Every grant exit passes through one IDLE cycle, which is the resource turnaround.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_vld
);

    localparam int            CW       = $clog2(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD - 1);

    arb_state_t      state;
    logic [ID_W-1:0] ptr;
    logic [CW-1:0]   hold_cnt;
    logic [ID_W-1:0] win_id;
    logic            win_vld;
    logic            contended;

    rr_pick8 u_pick (
        .req     (req),
        .ptr     (ptr),
        .win_id  (win_id),
        .win_vld (win_vld)
    );

    // While granted, gnt is one-hot on the owner, so masking it out leaves the competitors.
    assign contended = |(req & ~gnt);

    // Arbitration FSM: grant from IDLE, leave GRANT on disable, release or contended timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            gnt_vld  <= 1'b0;
            ptr      <= ID_W'(NREQ - 1);
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!en && win_vld) begin
                        state    <= GRANT;
                        gnt      <= onehot8(win_id);
                        gnt_id   <= win_id;
                        gnt_vld  <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (en) begin
                        state   <= IDLE;
                        gnt     <= '0;
                        gnt_id  <= '0;
                        gnt_vld <= 1'b0;
                    end else if (!req[gnt_id]) begin
                        state   <= IDLE;
                        gnt     <= '0;
                        gnt_id  <= '0;
                        gnt_vld <= 1'b0;
                        ptr     <= gnt_id;
                    end else if (hold_cnt == HOLD_MAX && contended) begin
                        state   <= IDLE;
                        gnt     <= '0;
                        gnt_id  <= '0;
                        gnt_vld <= 1'b0;
                        ptr     <= gnt_id;
                    end else if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + CW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    gnt     <= '0;
                    gnt_id  <= '0;
                    gnt_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_rr_arbiter8;

    localparam int MAXH = 4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_vld;

    int errors = 0;
    int checks = 0;

    // Behavioural model: current owner (-1 = none), last served index, cycles held so far.
    int mOwner;
    int mPtr;
    int mHeld;

    rr_arbiter8 #(.MAX_HOLD(MAXH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Next owner from the arbitration rules: scan ptr+1.. mod 8, hold limit only under contention.
    function automatic void modelStep(input int owner, input int ptr, input int held,
                                      input logic e, input logic [7:0] r,
                                      output int nOwner, output int nPtr, output int nHeld);
        logic [7:0] others;
        nOwner = owner;
        nPtr   = ptr;
        nHeld  = held;
        if (owner >= 0) begin
            others = r & ~(8'b1 << owner);
            if (e) begin
                nOwner = -1;
            end else if (!r[owner]) begin
                nPtr   = owner;
                nOwner = -1;
            end else if (held >= MAXH && others != 8'b0) begin
                nPtr   = owner;
                nOwner = -1;
            end else begin
                nHeld = held + 1;
            end
        end else if (!e) begin
            for (int k = 1; k <= 8; k++) begin
                if (nOwner < 0 && r[(ptr + k) % 8]) begin
                    nOwner = (ptr + k) % 8;
                    nHeld  = 1;
                end
            end
        end
    endfunction

    // Advance the model on each clock edge; asynchronous reset mirrors the DUT reset values.
    always @(posedge clk or negedge rst_n) begin : modelUpdate
        int o, p, h;
        if (!rst_n) begin
            mOwner <= -1;
            mPtr   <= 7;
            mHeld  <= 0;
        end else begin
            modelStep(mOwner, mPtr, mHeld, en, req, o, p, h);
            mOwner <= o;
            mPtr   <= p;
            mHeld  <= h;
        end
    end

    // Compare DUT outputs with the model on every falling edge outside reset.
    always @(negedge clk) begin : compareModel
        logic [7:0] expGnt;
        logic [2:0] expId;
        logic       expVld;
        if (rst_n) begin
            expVld = (mOwner >= 0);
            expGnt = expVld ? (8'b1 << mOwner) : 8'b0;
            expId  = expVld ? 3'(mOwner) : 3'd0;
            checks++;
            if (gnt !== expGnt || gnt_id !== expId || gnt_vld !== expVld) begin
                errors++;
                $display("[TB] FAIL model t=%0t: gnt=%h gnt_id=%0d gnt_vld=%b expected gnt=%h gnt_id=%0d gnt_vld=%b",
                         $time, gnt, gnt_id, gnt_vld, expGnt, expId, expVld);
            end
        end
    end

    // Drive one set of inputs and move to the next falling edge, past one rising edge.
    task automatic applyStimulus(input logic e, input logic [7:0] r);
        en  = e;
        req = r;
        @(negedge clk);
    endtask

    // Literal check: expId < 0 means no grant may be active.
    task automatic checkOutput(input string name, input int expId);
        logic [7:0] eg;
        logic [2:0] ei;
        logic       ev;
        ev = (expId >= 0);
        eg = ev ? (8'b1 << expId) : 8'b0;
        ei = ev ? 3'(expId) : 3'd0;
        checks++;
        if (gnt !== eg || gnt_id !== ei || gnt_vld !== ev) begin
            errors++;
            $display("[TB] FAIL %s: gnt=%h gnt_id=%0d gnt_vld=%b expected gnt=%h gnt_id=%0d gnt_vld=%b",
                     name, gnt, gnt_id, gnt_vld, eg, ei, ev);
        end
    endtask

    int toSeq [11] = '{2, 2, 2, 2, -1, 5, 5, 5, 5, -1, 2};

    initial begin
        logic [7:0] r;
        logic       e;
        rst_n = 1'b1;
        en    = 1'b1;
        req   = 8'h00;
        #1 rst_n = 1'b0;
        #2 checkOutput("reset_async", -1);
        @(negedge clk);
        req = 8'h81;
        en  = 1'b0;
        @(negedge clk);
        checkOutput("reset_hold", -1);
        rst_n = 1'b1;

        $display("[TB] first grant after reset");
        applyStimulus(1'b0, 8'h81);
        checkOutput("first_grant", 0);

        $display("[TB] rotation with all requesters");
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 8'hFF & ~(8'b1 << k));
            checkOutput("rot_bubble", -1);
            applyStimulus(1'b0, 8'hFF);
            checkOutput("rot_grant", (k + 1) % 8);
        end
        applyStimulus(1'b0, 8'h00);
        checkOutput("rot_release", -1);

        $display("[TB] contended timeout");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b0, 8'h24);
            checkOutput("timeout_seq", toSeq[i]);
        end
        applyStimulus(1'b0, 8'h00);
        checkOutput("timeout_release", -1);

        $display("[TB] uncontended hold");
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, 8'h08);
            checkOutput("hold_3", 3);
        end
        applyStimulus(1'b0, 8'h48);
        checkOutput("hold_bubble", -1);
        applyStimulus(1'b0, 8'h48);
        checkOutput("hold_to_6", 6);
        applyStimulus(1'b0, 8'h00);
        checkOutput("hold_release", -1);

        $display("[TB] enable withdrawal");
        applyStimulus(1'b0, 8'h10);
        checkOutput("en_grant4", 4);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'h30);
            checkOutput("en_disabled", -1);
        end
        applyStimulus(1'b0, 8'h30);
        checkOutput("en_regrant4", 4);
        applyStimulus(1'b0, 8'h00);
        checkOutput("en_release", -1);

        $display("[TB] reset mid-grant");
        applyStimulus(1'b0, 8'h40);
        checkOutput("mid_grant6", 6);
        #2 rst_n = 1'b0;
        #1 checkOutput("mid_reset_async", -1);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 8'hC0);
        checkOutput("post_reset6", 6);

        $display("[TB] randomized traffic");
        r = 8'hC0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                r = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom & $urandom);
            end
            e = ($urandom_range(0, 11) == 0);
            applyStimulus(e, r);
        end
        applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00);
        checkOutput("final_idle", -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
